// File: rtl/stream_demux_1xn.sv
// Registered 1-to-N valid/ready stream demultiplexer with one holding slot per channel.
// Optional broadcast (in_bcast port) is enabled with `define STREAM_DEMUX_BCAST_EN.
module stream_demux_1xn #(
  parameter int DATA_W = 32,
  parameter int N_OUT  = 16,
  parameter int SEL_W  = $clog2(N_OUT)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic [DATA_W-1:0]       in_data,
`ifdef STREAM_DEMUX_BCAST_EN
  input  logic                    in_bcast,
`endif
  output logic [N_OUT-1:0]        out_valid,
  input  logic [N_OUT-1:0]        out_ready,
  output logic [N_OUT*DATA_W-1:0] out_data,
  output logic                    sel_err
);

  localparam int N_PAD = 2 ** SEL_W;
  localparam logic [SEL_W:0] N_OUT_C = (SEL_W + 1)'(N_OUT);

  logic             hit;
  logic             sel_free;
  logic             accept;
  logic             bcast;
  logic             drop;
  logic [N_PAD-1:0] valid_pad;
  logic [N_PAD-1:0] ready_pad;
  logic [N_OUT-1:0] load;

  // Padding lets an out-of-range select index the status vectors safely.
  assign valid_pad = N_PAD'(out_valid);
  assign ready_pad = N_PAD'(out_ready);
  assign hit       = ({1'b0, in_sel} < N_OUT_C);
  assign sel_free  = ~hit | ~valid_pad[in_sel] | ready_pad[in_sel];

`ifdef STREAM_DEMUX_BCAST_EN
  assign bcast    = in_bcast;
  assign in_ready = rst_n & ~flush & (bcast ? (&(~out_valid | out_ready)) : sel_free);
`else
  assign bcast    = 1'b0;
  assign in_ready = rst_n & ~flush & sel_free;
`endif

  assign accept = in_valid & in_ready;
  assign drop   = accept & ~hit & ~bcast;

  always_comb begin
    load = '0;
    for (int k = 0; k < N_OUT; k++) begin
      load[k] = accept & (bcast | (hit & (in_sel == SEL_W'(k))));
    end
  end

  // A loading slot stays/goes FULL; a drained slot without refill goes EMPTY.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= '0;
      out_data  <= '0;
      sel_err   <= 1'b0;
    end else if (flush) begin
      out_valid <= '0;
      sel_err   <= 1'b0;
    end else begin
      sel_err <= drop;
      for (int k = 0; k < N_OUT; k++) begin
        if (load[k]) begin
          out_valid[k]                   <= 1'b1;
          out_data[k*DATA_W +: DATA_W]   <= in_data;
        end else if (out_ready[k]) begin
          out_valid[k]                   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_stream_demux_1xn.sv
// Directed self-checking bench for stream_demux_1xn (16-channel and 12-channel instances).
module tb_stream_demux_1xn;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;

  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_sel;
  logic [31:0]   in_data;
  logic [15:0]   out_valid;
  logic [15:0]   out_ready;
  logic [511:0]  out_data;
  logic          sel_err;
`ifdef STREAM_DEMUX_BCAST_EN
  logic          in_bcast;
`endif

  logic          in_valid12;
  logic          in_ready12;
  logic [3:0]    in_sel12;
  logic [31:0]   in_data12;
  logic [11:0]   out_valid12;
  logic [11:0]   out_ready12;
  logic [383:0]  out_data12;
  logic          sel_err12;
`ifdef STREAM_DEMUX_BCAST_EN
  logic          in_bcast12;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  stream_demux_1xn #(.DATA_W(32), .N_OUT(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_data(in_data),
`ifdef STREAM_DEMUX_BCAST_EN
    .in_bcast(in_bcast),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .sel_err(sel_err)
  );

  stream_demux_1xn #(.DATA_W(32), .N_OUT(12)) dut12 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid12), .in_ready(in_ready12), .in_sel(in_sel12), .in_data(in_data12),
`ifdef STREAM_DEMUX_BCAST_EN
    .in_bcast(in_bcast12),
`endif
    .out_valid(out_valid12), .out_ready(out_ready12), .out_data(out_data12), .sel_err(sel_err12)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [3:0] sel, input logic [31:0] data);
    in_valid = valid;
    in_sel   = sel;
    in_data  = data;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] chan(input int k);
    return out_data[k*32 +: 32];
  endfunction

  initial begin
    rst_n       = 1'b0;
    flush       = 1'b0;
    out_ready   = 16'hFFFF;
    in_valid12  = 1'b0;
    in_sel12    = 4'd0;
    in_data12   = 32'd0;
    out_ready12 = 12'hFFF;
`ifdef STREAM_DEMUX_BCAST_EN
    in_bcast    = 1'b0;
    in_bcast12  = 1'b0;
`endif
    applyStimulus(1'b1, 4'd5, 32'hA5A5_0005);

    // Reset held three cycles with a pending beat
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
      checkOutput("rst_out_valid", 64'(out_valid), 64'h0);
      checkOutput("rst_out_data", 64'(|out_data), 64'd0);
      checkOutput("rst_sel_err", 64'(sel_err), 64'd0);
    end
    rst_n = 1'b1;
    #1;
    checkOutput("post_rst_in_ready", 64'(in_ready), 64'd1);
    tick();
    applyStimulus(1'b0, 4'd0, 32'd0);
    checkOutput("first_beat_valid", 64'(out_valid), 64'h0020);
    checkOutput("first_beat_data", 64'(chan(5)), 64'hA5A5_0005);

    // Back-to-back sweep across all channels
    for (int s = 0; s < 16; s++) begin
      applyStimulus(1'b1, 4'(s), 32'h100 + 32'(s));
      #1;
      checkOutput("sweep_in_ready", 64'(in_ready), 64'd1);
      tick();
      checkOutput("sweep_onehot", 64'(out_valid), 64'(16'h1 << s));
      checkOutput("sweep_data", 64'(chan(s)), 64'(32'h100 + 32'(s)));
    end
    applyStimulus(1'b0, 4'd0, 32'd0);
    tick();
    checkOutput("sweep_drained", 64'(out_valid), 64'h0);

    // Stall on channel 3, then drain/refill without bubble, then channel 7
    out_ready = 16'hFFF7;
    applyStimulus(1'b1, 4'd3, 32'h33);
    #1;
    checkOutput("stall_first_ready", 64'(in_ready), 64'd1);
    tick();
    checkOutput("stall_first_valid", 64'(out_valid), 64'h0008);
    applyStimulus(1'b1, 4'd3, 32'h44);
    #1;
    checkOutput("stall_blocked", 64'(in_ready), 64'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      checkOutput("stall_hold_valid", 64'(out_valid), 64'h0008);
      checkOutput("stall_hold_data", 64'(chan(3)), 64'h33);
    end
    out_ready = 16'hFFFF;
    #1;
    checkOutput("stall_release_ready", 64'(in_ready), 64'd1);
    tick();
    checkOutput("refill_valid", 64'(out_valid), 64'h0008);
    checkOutput("refill_data", 64'(chan(3)), 64'h44);
    applyStimulus(1'b1, 4'd7, 32'h77);
    #1;
    checkOutput("ch7_ready", 64'(in_ready), 64'd1);
    tick();
    checkOutput("ch7_valid", 64'(out_valid), 64'h0080);
    checkOutput("ch7_data", 64'(chan(7)), 64'h77);
    applyStimulus(1'b0, 4'd0, 32'd0);
    tick();

    // Flush with channels 1, 2, 9 full and an input beat pending
    out_ready = 16'h0000;
    applyStimulus(1'b1, 4'd1, 32'h11);
    tick();
    applyStimulus(1'b1, 4'd2, 32'h22);
    tick();
    applyStimulus(1'b1, 4'd9, 32'h99);
    tick();
    checkOutput("fill_valid", 64'(out_valid), 64'h0206);
    flush = 1'b1;
    applyStimulus(1'b1, 4'd4, 32'h4444);
    #1;
    checkOutput("flush_in_ready", 64'(in_ready), 64'd0);
    tick();
    flush = 1'b0;
    checkOutput("flush_cleared", 64'(out_valid), 64'h0);
    checkOutput("flush_data_kept", 64'(chan(1)), 64'h11);
    #1;
    checkOutput("post_flush_ready", 64'(in_ready), 64'd1);
    tick();
    checkOutput("post_flush_valid", 64'(out_valid), 64'h0010);
    checkOutput("post_flush_data", 64'(chan(4)), 64'h4444);
    applyStimulus(1'b0, 4'd0, 32'd0);
    out_ready = 16'hFFFF;
    tick();

    // Out-of-range select on the 12-channel instance
    in_valid12 = 1'b1;
    in_sel12   = 4'd13;
    in_data12  = 32'hDEAD;
    #1;
    checkOutput("oor_in_ready", 64'(in_ready12), 64'd1);
    checkOutput("oor_no_err_yet", 64'(sel_err12), 64'd0);
    tick();
    in_valid12 = 1'b0;
    checkOutput("oor_sel_err", 64'(sel_err12), 64'd1);
    checkOutput("oor_out_valid", 64'(out_valid12), 64'h0);
    tick();
    checkOutput("oor_sel_err_pulse", 64'(sel_err12), 64'd0);
    checkOutput("oor_out_valid_after", 64'(out_valid12), 64'h0);

`ifdef STREAM_DEMUX_BCAST_EN
    // Broadcast blocked by a stalled channel, then released
    out_ready = 16'hFFEF;
    applyStimulus(1'b1, 4'd4, 32'h4);
    tick();
    in_bcast = 1'b1;
    applyStimulus(1'b1, 4'd0, 32'hBEEF);
    #1;
    checkOutput("bcast_blocked", 64'(in_ready), 64'd0);
    tick();
    checkOutput("bcast_wait_valid", 64'(out_valid), 64'h0010);
    out_ready = 16'hFFFF;
    #1;
    checkOutput("bcast_ready", 64'(in_ready), 64'd1);
    tick();
    in_bcast = 1'b0;
    applyStimulus(1'b0, 4'd0, 32'd0);
    checkOutput("bcast_all_valid", 64'(out_valid), 64'hFFFF);
    checkOutput("bcast_ch0", 64'(chan(0)), 64'hBEEF);
    checkOutput("bcast_ch15", 64'(chan(15)), 64'hBEEF);
    checkOutput("bcast_no_err", 64'(sel_err), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/stream_demux_1xn.md
Name: stream_demux_1xn

Overview:
- Parametrised, registered 1-to-N stream demultiplexer with a valid/ready handshake on the input and on every output channel.
- Each output channel has a one-entry holding register, so a stall on one channel only blocks input beats addressed to that channel.
- Sits in the 2-issue datapath where a result or uop is steered by an index to one of N consumers (FU ports, ROB banks).
- Supports pipeline flush on branch mispredict.

Parameters:
DATA_W, 32, width of the data payload in bits
N_OUT, 16, number of output channels (2..64)
SEL_W, $clog2(N_OUT), width of the channel select; derived, do not override

Ports:
clk  input  1  clock; all logic is rising-edge
rst_n  input  1  reset; synchronous, active-low
flush  input  1  synchronous clear of all holding registers
in_valid  input  1  input beat present
in_ready  output  1  input beat accepted this cycle when in_valid & in_ready
in_sel  input  SEL_W  destination channel index
in_data  input  DATA_W  payload
out_valid  output  N_OUT  per-channel beat present
out_ready  input  N_OUT  per-channel consumer accepts
out_data  output  N_OUT*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W]
sel_err  output  1  registered pulse: out-of-range select was accepted and dropped

Behaviour:
- Reset: the clock and reset are as stated above (one clock; synchronous, active-low reset).
  - While rst_n = 0 at a rising edge: all out_valid = 0, all out_data = 0, sel_err = 0.
  - in_ready is combinational and reads 0 while rst_n = 0.
  - Reset mid-transfer discards every held beat. No beat is accepted in a reset cycle.
- Per-channel state: slot_k is EMPTY or FULL. out_valid[k] = FULL.
- Input acceptance:
  - hit = in_sel < N_OUT.
  - in_ready = rst_n & ~flush & (~hit | ~out_valid[in_sel] | out_ready[in_sel]).
  - in_ready is combinational from in_sel, out_valid and out_ready. It does not depend on in_valid.
- Transitions for channel k each edge, with acc = in_valid & in_ready & hit & (in_sel == k):
  - EMPTY, acc: FULL, out_data_k <= in_data.
  - FULL, out_ready[k] & ~acc: EMPTY, data held at its last value.
  - FULL, out_ready[k] & acc: stays FULL, out_data_k <= in_data. This is simultaneous drain and refill with no bubble, giving full throughput per channel.
  - FULL, ~out_ready[k]: holds. acc cannot occur.
- Latency: an accepted beat appears on out_valid/out_data at the next edge, so latency is 1 cycle.
- Output stability: out_data_k does not change while out_valid[k] = 1 and out_ready[k] = 0.
- Out-of-range select (in_sel >= N_OUT, only possible when N_OUT is not a power of 2):
  - The beat is always accepted and discarded.
  - sel_err = 1 for exactly the following cycle.
- Flush:
  - flush = 1 at an edge clears every out_valid to 0 at that edge.
  - in_ready = 0 during the flush cycle. out_ready is ignored in that cycle.
  - Data registers keep their values.
  - flush has lower priority than reset.
- Channels are independent: beats to different channels may be accepted on consecutive cycles while other channels stall.
- Ordering: beats to the same channel are delivered in acceptance order. There is no ordering guarantee across channels.

Optional Feature:
- Macro: STREAM_DEMUX_BCAST_EN.
- Defined:
  - Adds input port in_bcast (1 bit).
  - When in_valid & in_bcast, in_ready requires every channel to be EMPTY or draining this cycle.
  - On acceptance, all N_OUT slots load in_data and go FULL on the same edge. in_sel is ignored and sel_err is not raised.
- Not defined:
  - The port is absent and there is no broadcast logic. Behaviour is exactly as above.

Test Plan:
- Reset: hold rst_n = 0 for 3 cycles with in_valid = 1, in_sel = 5 -> in_ready = 0, out_valid = 0x0000, out_data all zero. Release -> the first beat 0xA5A5_0005 appears on channel 5 one cycle later.
- Sweep with N_OUT = 16 and all out_ready = 1: send in_sel = 0..15 with data = 0x100 + sel on back-to-back cycles -> one-hot out_valid walks bit 0..15. Each channel carries its own data. in_ready stays 1 throughout (16 beats in 16 cycles).
- Stall and independence: out_ready[3] = 0; send sel 3 (0x33), then sel 3 (0x44), then sel 7 (0x77):
  - The second beat stalls (in_ready = 0) while channel 3 holds 0x33 stable.
  - Raise out_ready[3] -> 0x44 is accepted in that same cycle, giving a drain/refill with no bubble.
  - 0x77 then reaches channel 7.
- Flush: fill channels 1, 2 and 9, and assert flush for 1 cycle with in_valid = 1 -> out_valid = 0 on the next cycle and the input beat is not accepted. Deassert flush -> the beat is accepted normally.
- Out-of-range select with N_OUT = 12: in_sel = 13, data 0xDEAD -> accepted, sel_err = 1 for one cycle, out_valid stays 0.
- STREAM_DEMUX_BCAST_EN: with channel 4 FULL and stalled, send in_bcast = 1 -> in_ready = 0. Release out_ready[4] -> all 16 out_valid = 1 with data 0xBEEF after one cycle.
